// File: rtl/rename_table.sv
// Two-slot register rename table: arch->phys map, circular free list of
// physical tags and a single branch checkpoint restored on flush.
module rename_table #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0][4:0]     q_rs_1,
  input  logic [1:0][4:0]     q_rs_2,
  input  logic [1:0][4:0]     q_rd,
  input  logic [1:0]          q_rename,
  input  logic [1:0]          q_jumps,
  input  logic                q_commit,
  output logic [1:0][5:0]     o_rs_1,
  output logic [1:0][5:0]     o_rs_2,
  output logic [1:0][5:0]     o_rn,
  input  logic [1:0]          ret_free,
  input  logic [1:0][5:0]     ret_reg,
  input  logic                branch_ok,
  input  logic                flush,
  output logic                spec_active,
  output logic [5:0]          free_count
);

  localparam int TW = 6;
  localparam int FL = PHYS_REGS - ARCH_REGS;
  localparam int FW = $clog2(FL);

  logic [TW-1:0] map_q  [ARCH_REGS];
  logic [TW-1:0] ckpt_q [ARCH_REGS];
  logic [TW-1:0] fl_q   [FL];
  logic [FW:0]   head_q, tail_q, ckpt_head_q;
  logic          spec_q;

  logic [TW-1:0] map_s0 [ARCH_REGS];
  logic [TW-1:0] map_s1 [ARCH_REGS];
  logic [TW-1:0] fl_d   [FL];
  logic [FW:0]   tail_d, head_s0, head_s1;
  logic [FW:0]   cnt, need1, idx1;
  logic [TW-1:0] rn0, rn1;
  logic          ok, pop0, pop1, push_err;

  assign cnt         = tail_q - head_q;
  assign free_count  = TW'(cnt);
  assign spec_active = spec_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      o_rs_1[i] = (q_rs_1[i] == '0) ? '0 : map_q[q_rs_1[i]];
      o_rs_2[i] = (q_rs_2[i] == '0) ? '0 : map_q[q_rs_2[i]];
    end
  end

  // Slot 1 takes the entry behind slot 0 only when slot 0 also renames.
  assign need1 = q_rename[0] ? (FW+1)'(2) : (FW+1)'(1);
  assign idx1  = head_q + {{FW{1'b0}}, q_rename[0]};
  assign rn0   = (q_rename[0] && cnt != '0) ? fl_q[head_q[FW-1:0]] : '0;
  assign rn1   = (q_rename[1] && cnt >= need1) ? fl_q[idx1[FW-1:0]] : '0;
  assign o_rn[0] = rn0;
  assign o_rn[1] = rn1;

  assign ok = q_commit && !flush
              && !(q_rename[0] && rn0 == '0)
              && !(q_rename[1] && rn1 == '0);
  assign pop0 = ok && q_rename[0];
  assign pop1 = ok && q_rename[1];
  assign head_s0 = head_q + {{FW{1'b0}}, pop0};
  assign head_s1 = head_s0 + {{FW{1'b0}}, pop1};

  always_comb begin
    map_s0 = map_q;
    if (pop0 && q_rd[0] != '0) map_s0[q_rd[0]] = rn0;
    map_s1 = map_s0;
    if (pop1 && q_rd[1] != '0) map_s1[q_rd[1]] = rn1;
  end

  always_comb begin
    fl_d     = fl_q;
    tail_d   = tail_q;
    push_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (ret_free[i] && ret_reg[i] != '0) begin
        if (tail_d - head_q == (FW+1)'(FL)) begin
          push_err = 1'b1;
        end else begin
          fl_d[tail_d[FW-1:0]] = ret_reg[i];
          tail_d = tail_d + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i]  <= TW'(i);
        ckpt_q[i] <= TW'(i);
      end
      for (int i = 0; i < FL; i++) fl_q[i] <= TW'(ARCH_REGS + i);
      head_q      <= '0;
      tail_q      <= (FW+1)'(FL);
      ckpt_head_q <= '0;
      spec_q      <= 1'b0;
    end else begin
      fl_q   <= fl_d;
      tail_q <= tail_d;
      if (flush && spec_q) begin
        map_q  <= ckpt_q;
        head_q <= ckpt_head_q;
        spec_q <= 1'b0;
      end else begin
        map_q  <= map_s1;
        head_q <= head_s1;
        if (ok && !spec_q && q_jumps[0]) begin
          ckpt_q      <= map_s0;
          ckpt_head_q <= head_s0;
          spec_q      <= 1'b1;
        end else if (ok && !spec_q && q_jumps[1]) begin
          ckpt_q      <= map_s1;
          ckpt_head_q <= head_s1;
          spec_q      <= 1'b1;
        end else if (branch_ok) begin
          spec_q <= 1'b0;
        end
      end
    end
  end

  a_push_full: assert property (@(posedge clock) disable iff (reset) !push_err);

endmodule
